grant_burst_ctrl: RTL and testbench

- Downstream consumer of the two-requester arbiter's grant outputs.
- Latches the granted requester, then moves a fixed-length burst of data beats from that requester onto one shared valid/ready output channel.
- Pulses a completion strobe when the burst has fully drained, so the requester can drop its request and the arbiter can re-grant.

---
 rtl/grant_burst_pkg.sv | 15 +
 rtl/grant_burst_out_reg.sv | 46 ++++
 rtl/grant_burst_ctrl.sv | 158 +++++++++++++++
 tb/tb_grant_burst_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grant_burst_pkg.sv
// grant_burst_pkg: shared state encoding and default sizes
// for the grant-driven burst controller.
package grant_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/grant_burst_out_reg.sv
// grant_burst_out_reg: single-entry registered valid/ready slot.
// in: load/load_data/out_ready  out: out_valid/out_data/slot_free
module grant_burst_out_reg
  import grant_burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              slot_free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign slot_free = !valid_q || out_ready;

endmodule

// File: rtl/grant_burst_ctrl.sv
// grant_burst_ctrl: latches the granted requester and moves a
// BURST_LEN-beat burst to one valid/ready output, then pulses
// burst_done. Ports: clock, reset(async low), grant_0/1,
// valid_/data_/ready_0/1, out_valid/out_data/out_src/out_ready,
// burst_done. Macro GRANT_BURST_TIMEOUT_EN adds a BURST
// watchdog (TIMEOUT) and the burst_abort output.
module grant_burst_ctrl
  import grant_burst_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CNT_W     = 8
`ifdef GRANT_BURST_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              grant_0,
  input  logic              grant_1,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] data_0,
  output logic              ready_0,
  input  logic              valid_1,
  input  logic [DATA_W-1:0] data_1,
  output logic              ready_1,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              burst_done
`ifdef GRANT_BURST_TIMEOUT_EN
  ,
  output logic              burst_abort
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              src_q, src_d;
  logic              slot_free;
  logic              grant_any;
  logic              valid_own;
  logic [DATA_W-1:0] data_own;
  logic              ready_own;
  logic              accept;
  logic              last_beat;
  logic              wd_fire;

  assign grant_any = grant_0 | grant_1;
  assign valid_own = src_q ? valid_1 : valid_0;
  assign data_own  = src_q ? data_1 : data_0;
  assign ready_own = (state_q == BURST) && slot_free;
  assign accept    = valid_own && ready_own;
  assign last_beat = accept && (cnt_q == CNT_W'(1));

`ifdef GRANT_BURST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            abort_q, abort_d;

  // Fires on the TIMEOUT-th consecutive beat-less BURST cycle.
  assign wd_fire = (state_q == BURST) && !accept &&
                   (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_d    = wd_q;
    abort_d = abort_q;
    if (state_q == IDLE) begin
      wd_d = '0;
      if (grant_any) abort_d = 1'b0;
    end else if (state_q == BURST) begin
      wd_d = accept ? '0 : wd_q + WD_W'(1);
      if (wd_fire) abort_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      abort_q <= abort_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d = BURST;
          cnt_d   = CNT_W'(BURST_LEN);
          src_d   = !grant_0;
        end
      end
      BURST: begin
        if (accept) cnt_d = cnt_q - CNT_W'(1);
        if (last_beat || wd_fire) state_d = DRAIN;
      end
      // Leave once the final beat is gone or leaving now.
      DRAIN: begin
        if (slot_free) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ready_0    = ready_own && !src_q;
    ready_1    = ready_own && src_q;
    burst_done = (state_q == DONE);
`ifdef GRANT_BURST_TIMEOUT_EN
    burst_abort = (state_q == DONE) && abort_q;
`endif
  end

  assign out_src = src_q;

  grant_burst_out_reg #(
    .DATA_W(DATA_W)
  ) u_out (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_data(data_own),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .slot_free(slot_free)
  );

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// tb_grant_burst_ctrl: directed and random stimulus against a
// queue-based transaction model of the burst controller.
module tb_grant_burst_ctrl;

  localparam int BL  = 4;
  localparam int TMO = 16;

  logic       clock;
  logic       reset;
  logic       grant_0, grant_1;
  logic       valid_0, valid_1;
  logic [7:0] data_0, data_1;
  logic       ready_0, ready_1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_ready;
  logic       burst_done;
  logic       burst_abort;

  grant_burst_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .grant_0   (grant_0),
    .grant_1   (grant_1),
    .valid_0   (valid_0),
    .data_0    (data_0),
    .ready_0   (ready_0),
    .valid_1   (valid_1),
    .data_1    (data_1),
    .ready_1   (ready_1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .burst_done(burst_done)
`ifdef GRANT_BURST_TIMEOUT_EN
    ,
    .burst_abort(burst_abort)
`endif
  );

`ifndef GRANT_BURST_TIMEOUT_EN
  assign burst_abort = 1'b0;
`endif

  initial clock = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: pending output beats, beats still owed by the
  // owner, and the burst life-cycle flags.
  logic [7:0] m_q[$];
  logic [7:0] m_data;
  logic       m_src;
  int         m_left;
  bit         m_acc, m_drain, m_done;
  int         m_wd;
  bit         m_abort;
  bit         last_acc;
  int         n_out, n_done, n_abort;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_q.delete();
    m_data  = '0;
    m_src   = 1'b0;
    m_left  = 0;
    m_acc   = 0;
    m_drain = 0;
    m_done  = 0;
    m_wd    = 0;
    m_abort = 0;
  endtask

  task automatic step(input logic g0, input logic g1,
                      input logic v0, input logic v1,
                      input logic [7:0] d0,
                      input logic [7:0] d1,
                      input logic ordy);
    bit free, acc, idle, old_drain;
    grant_0   = g0;
    grant_1   = g1;
    valid_0   = v0;
    valid_1   = v1;
    data_0    = d0;
    data_1    = d1;
    out_ready = ordy;
    #1;
    free = (m_q.size() == 0) || ordy;
    chk("ready_0", ready_0, m_acc && !m_src && free);
    chk("ready_1", ready_1, m_acc && m_src && free);
    if (out_valid && ordy) n_out++;
    acc = m_acc && free && (m_src ? v1 : v0);
    last_acc = acc;
    idle = !m_acc && !m_drain && !m_done;
    old_drain = m_drain;
    m_done = 0;
    if (old_drain && free) begin
      m_drain = 0;
      m_done  = 1;
    end
    if (ordy && m_q.size() > 0) void'(m_q.pop_front());
    if (m_acc) begin
      if (acc) begin
        m_data = m_src ? d1 : d0;
        m_q.push_back(m_data);
        m_left--;
        m_wd = 0;
        if (m_left == 0) begin
          m_acc   = 0;
          m_drain = 1;
        end
      end
`ifdef GRANT_BURST_TIMEOUT_EN
      else begin
        m_wd++;
        if (m_wd == TMO) begin
          m_acc   = 0;
          m_drain = 1;
          m_abort = 1;
        end
      end
`endif
    end else if (idle && (g0 || g1)) begin
      m_src   = !g0;
      m_left  = BL;
      m_acc   = 1;
      m_wd    = 0;
      m_abort = 0;
    end
    @(negedge clock);
    chk("out_valid", out_valid, m_q.size() != 0);
    chk("out_data", out_data, m_data);
    chk("out_src", out_src, m_src);
    chk("burst_done", burst_done, m_done);
`ifdef GRANT_BURST_TIMEOUT_EN
    chk("burst_abort", burst_abort, m_done && m_abort);
`endif
    if (burst_done) n_done++;
    if (burst_abort) n_abort++;
  endtask

  initial begin
    logic [7:0] d;
    int cnt;
    reset     = 1'b0;
    grant_0   = 1'b0;
    grant_1   = 1'b0;
    valid_0   = 1'b0;
    valid_1   = 1'b0;
    data_0    = '0;
    data_1    = '0;
    out_ready = 1'b0;
    mdl_reset();
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_src", out_src, 1'b0);
    chk("rst_done", burst_done, 1'b0);
    chk("rst_r0", ready_0, 1'b0);
    chk("rst_r1", ready_1, 1'b0);
    #3;
    reset = 1'b1;

    // single grant, A0..A3
    d = 8'hA0;
    n_out = 0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      step(i < 2, 1'b0, 1'b1, 1'b0, d, 8'h00, 1'b1);
      if (last_acc) d++;
    end
    chk("t1_beats", 8'(n_out), 8'd4);
    chk("t1_dones", 8'(n_done), 8'd1);

    // back-pressure after first beat
    d = 8'hA0;
    n_out = 0;
    for (int i = 0; i < 16; i++) begin
      step(i < 2, 1'b0, 1'b1, 1'b0, d, 8'h00,
           !(i >= 2 && i <= 4));
      if (last_acc) d++;
    end
    chk("t2_beats", 8'(n_out), 8'd4);

    // both grants
    d = 8'hB0;
    for (int i = 0; i < 12; i++) begin
      step(i < 2, i < 2, 1'b1, 1'b1, d, 8'h5A, 1'b1);
      if (last_acc) d++;
    end

    // grant switch mid-burst
    d = 8'hC0;
    n_done = 0;
    for (int i = 0; i < 22; i++) begin
      step(i < 3, i >= 3 && i < 12, 1'b1, 1'b1,
           d, 8'h50 + 8'(i), 1'b1);
      if (last_acc) d++;
    end
    chk("t4_dones", 8'(n_done), 8'd2);

    // reset mid-burst
    d = 8'h30;
    cnt = 0;
    for (int i = 0; i < 10 && cnt < 2; i++) begin
      step(i < 1, 1'b0, 1'b1, 1'b0, d, 8'h00, 1'b1);
      if (last_acc) begin
        d++;
        cnt++;
      end
    end
    chk("t5_acc", 8'(cnt), 8'd2);
    chk("t5_pre_valid", out_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_done", burst_done, 1'b0);
    chk("t5_r0", ready_0, 1'b0);
    chk("t5_r1", ready_1, 1'b0);
    mdl_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(i >= 2 && i < 4, 1'b0, 1'b1, 1'b0, d, 8'h00, 1'b1);
      if (last_acc) d++;
    end

`ifdef GRANT_BURST_TIMEOUT_EN
    // watchdog abort, then a fresh full burst
    n_done = 0;
    n_abort = 0;
    for (int i = 0; i < 26; i++) begin
      step(i < 1, 1'b0, i < 2, 1'b0, 8'hD0, 8'h00, 1'b1);
    end
    chk("t6_dones", 8'(n_done), 8'd1);
    chk("t6_aborts", 8'(n_abort), 8'd1);
    d = 8'hE0;
    n_out = 0;
    for (int i = 0; i < 12; i++) begin
      step(i < 1, 1'b0, 1'b1, 1'b0, d, 8'h00, 1'b1);
      if (last_acc) d++;
    end
    chk("t6_beats", 8'(n_out), 8'd4);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           8'($urandom), 8'($urandom),
           $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
